// File: rtl/pipeline_stage_reg.sv
// rtl/pipeline_stage_reg.sv - flow-controlled inter-stage pipeline register, optional skid slot (PIPE_STAGE_SKID_EN)
// All state updates on the falling edge; invalid slots always present zero control bits.
module pipeline_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              up_valid_i,
    output logic              up_ready_o,
    input  logic [DATA_W-1:0] up_data_i,
    input  logic [CTRL_W-1:0] up_ctrl_i,
    output logic              dn_valid_o,
    input  logic              dn_ready_i,
    output logic [DATA_W-1:0] dn_data_o,
    output logic [CTRL_W-1:0] dn_ctrl_o
);

    logic              r_main_valid;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;

    logic w_up_xfer;
    logic w_dn_xfer;
    logic w_main_load;

    assign w_up_xfer   = up_valid_i & up_ready_o;
    assign w_dn_xfer   = r_main_valid & dn_ready_i;
    // Main slot may take a new entry when it is empty or being consumed this edge.
    assign w_main_load = w_dn_xfer | ~r_main_valid;

    assign dn_valid_o = r_main_valid;
    assign dn_data_o  = r_main_data;
    assign dn_ctrl_o  = r_main_ctrl & {CTRL_W{r_main_valid}};

`ifdef PIPE_STAGE_SKID_EN
    logic              r_skid_valid;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;

    // Ready depends only on registered state, breaking the ready path across stages.
    assign up_ready_o = ~r_skid_valid & ~rst;

    always_ff @(negedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_ctrl  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_ctrl  <= '0;
        end else if (flush_i) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
        end else if (w_main_load) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_data  <= r_skid_data;
                r_main_ctrl  <= r_skid_ctrl;
                r_skid_valid <= 1'b0;
                r_skid_ctrl  <= '0;
            end else if (w_up_xfer) begin
                r_main_valid <= 1'b1;
                r_main_data  <= up_data_i;
                r_main_ctrl  <= up_ctrl_i;
            end else begin
                r_main_valid <= 1'b0;
                r_main_ctrl  <= '0;
            end
        end else if (w_up_xfer) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= up_data_i;
            r_skid_ctrl  <= up_ctrl_i;
        end
    end
`else
    assign up_ready_o = (dn_ready_i | ~r_main_valid) & ~rst;

    always_ff @(negedge clk) begin
        if (rst) begin
            r_main_valid <= 1'b0;
            r_main_data  <= '0;
            r_main_ctrl  <= '0;
        end else if (flush_i) begin
            r_main_valid <= 1'b0;
            r_main_ctrl  <= '0;
        end else if (w_main_load) begin
            if (w_up_xfer) begin
                r_main_valid <= 1'b1;
                r_main_data  <= up_data_i;
                r_main_ctrl  <= up_ctrl_i;
            end else begin
                r_main_valid <= 1'b0;
                r_main_ctrl  <= '0;
            end
        end
    end
`endif

endmodule
